// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory request/ready handshake bundle
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage PC sequencer with delay-slot redirect and stall buffer
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      branch,
  input  logic                      jump,
  input  logic [31:0]               branch_addr,
  input  logic [31:0]               jump_addr,
  fetch_sequencer_if.master         imem,
  output logic                      if_valid,
  output logic [31:0]               if_instr,
  output logic [31:0]               if_pc,
  output logic [31:0]               if_pc_4,
  output logic                      redirect_pending
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_pc_q, if_pc_4_q;
  logic        pend_q, pend_d;
  logic [31:0] pend_addr_q, pend_addr_d;

  logic        fire;
  logic        redirect;
  logic [31:0] target;

  assign imem.imem_req  = (state_q == FETCH) && (!if_valid_q || !stall);
  assign imem.imem_addr = pc_q;

  assign fire     = imem.imem_req && imem.imem_ready;
  assign redirect = branch || jump;
  assign target   = jump ? jump_addr : branch_addr;

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    if_valid_d  = if_valid_q;

    if (fire) begin
      if (pend_q)
        pc_d = pend_addr_q;
      else if (redirect)
        pc_d = target;
      else
        pc_d = pc_q + 32'd4;
    end

    // A redirect coinciding with a completion with nothing pending makes that
    // completion the delay slot, so the target goes straight into pc instead.
    if (redirect && !(fire && !pend_q)) begin
      pend_addr_d = target;
      pend_d      = 1'b1;
    end else if (fire) begin
      pend_d      = 1'b0;
    end

    if (fire)
      if_valid_d = 1'b1;
    else if (if_valid_q && !stall)
      if_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'd0;
      if_pc_q     <= 32'd0;
      if_pc_4_q   <= 32'd4;
      pend_q      <= 1'b0;
      pend_addr_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE:    state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      if_valid_q  <= if_valid_d;
      if (fire) begin
        if_instr_q <= imem.imem_rdata;
        if_pc_q    <= pc_q;
        if_pc_4_q  <= pc_q + 32'd4;
      end
    end
  end

  assign if_valid         = if_valid_q;
  assign if_instr         = if_instr_q;
  assign if_pc            = if_pc_q;
  assign if_pc_4          = if_pc_4_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer against a reference model
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        jump;
  logic [31:0] branch_addr;
  logic [31:0] jump_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_4;
  logic        redirect_pending;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch           (branch),
    .jump             (jump),
    .branch_addr      (branch_addr),
    .jump_addr        (jump_addr),
    .imem             (imem_bus.master),
    .if_valid         (if_valid),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_pc_4          (if_pc_4),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage.
  bit          m_started;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr, m_ifpc;
  bit          m_pend;
  logic [31:0] m_paddr;

  task automatic model_reset();
    m_started = 0;
    m_pc      = 32'h0000_3000;
    m_valid   = 0;
    m_instr   = 0;
    m_ifpc    = 0;
    m_pend    = 0;
    m_paddr   = 0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    check_eq({tag, ".instr"}, if_instr, m_instr);
    check_eq({tag, ".pc"}, if_pc, m_ifpc);
    check_eq({tag, ".pc4"}, if_pc_4, m_ifpc + 32'd4);
    check_eq({tag, ".pend"}, {31'd0, redirect_pending}, {31'd0, m_pend});
    check_eq({tag, ".addr"}, imem_bus.imem_addr, m_pc);
  endtask

  // One clock: drive at negedge, check the combinational request, advance the
  // model across the posedge, then check registered state at the next negedge.
  task automatic cycle(input bit s, input bit br, input bit jp,
                       input logic [31:0] ba, input logic [31:0] ja, input bit rdy);
    bit          req, done, redir, had_pend;
    logic [31:0] tgt, rd;
    rd = $urandom;
    stall = s; branch = br; jump = jp; branch_addr = ba; jump_addr = ja;
    imem_bus.imem_ready = rdy; imem_bus.imem_rdata = rd;
    #1;
    req = m_started && (!m_valid || !s);
    check_eq("req", {31'd0, imem_bus.imem_req}, {31'd0, req});
    done     = req && rdy;
    redir    = br || jp;
    tgt      = jp ? ja : ba;
    had_pend = m_pend;
    if (done) begin
      m_instr = rd;
      m_ifpc  = m_pc;
      m_valid = 1;
      m_pc    = had_pend ? m_paddr : (redir ? tgt : m_pc + 32'd4);
      if (had_pend && !redir) m_pend = 0;
    end else if (m_valid && !s) begin
      m_valid = 0;
    end
    if (redir && !(done && !had_pend)) begin
      m_paddr = tgt;
      m_pend  = 1;
    end
    m_started = 1;
    @(negedge clk);
    check_state("cyc");
  endtask

  task automatic run(input bit s, input bit rdy);
    cycle(s, 1'b0, 1'b0, 32'd0, 32'd0, rdy);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; branch = 0; jump = 0; branch_addr = 0; jump_addr = 0;
    imem_bus.imem_ready = 0; imem_bus.imem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst.req", {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("rst.pc4", if_pc_4, 32'd4);
    check_state("rst");
    rst_n = 1'b1;

    // Sequential fetch with zero-wait memory
    run(0, 1);
    run(0, 1);
    check_eq("seq.first", if_pc, 32'h3000);
    run(0, 1);
    check_eq("seq.second", if_pc, 32'h3004);

    // Stall holds the buffer
    repeat (3) run(1, 1);
    check_eq("stall.hold", if_pc, 32'h3004);
    run(0, 1);
    check_eq("stall.release", if_pc, 32'h3008);

    // Slow memory with branch while the fetch is outstanding
    cycle(0, 1, 0, 32'h3100, 32'd0, 0);
    check_eq("br.pend", {31'd0, redirect_pending}, 32'd1);
    run(0, 0);
    run(0, 1);
    check_eq("br.slot", if_pc, 32'h300C);
    check_eq("br.target", imem_bus.imem_addr, 32'h3100);
    check_eq("br.clear", {31'd0, redirect_pending}, 32'd0);
    run(0, 1);

    // Jump beats branch on a coincident completion
    cycle(0, 1, 1, 32'h5000, 32'h4000, 1);
    check_eq("jp.addr", imem_bus.imem_addr, 32'h4000);
    check_eq("jp.nopend", {31'd0, redirect_pending}, 32'd0);
    run(0, 1);
    check_eq("jp.next", if_pc, 32'h4000);

    // PC wrap
    cycle(0, 0, 1, 32'd0, 32'hFFFF_FFF8, 1);
    run(0, 1);
    check_eq("wrap.f8", if_pc, 32'hFFFF_FFF8);
    run(0, 1);
    check_eq("wrap.fc", if_pc, 32'hFFFF_FFFC);
    run(0, 1);
    check_eq("wrap.0", if_pc, 32'h0000_0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r_br, r_jp;
      r_br = ($urandom_range(0, 9) == 0);
      r_jp = ($urandom_range(0, 14) == 0);
      cycle($urandom_range(0, 9) < 3, r_br, r_jp, $urandom, $urandom,
            $urandom_range(0, 9) < 6);
    end

    // Async reset with a request outstanding and a redirect pending
    stall = 0;
    run(0, 1);
    cycle(0, 1, 0, 32'h1234, 32'd0, 0);
    check_eq("ar.prepend", {31'd0, redirect_pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar.req", {31'd0, imem_bus.imem_req}, 32'd0);
    check_eq("ar.valid", {31'd0, if_valid}, 32'd0);
    check_eq("ar.pend", {31'd0, redirect_pending}, 32'd0);
    check_eq("ar.addr", imem_bus.imem_addr, 32'h3000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1);
    run(0, 1);
    check_eq("ar.resume", if_pc, 32'h3000);
    run(0, 1);
    check_eq("ar.resume2", if_pc, 32'h3004);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
